// File: rtl/i2s_tdm_pkg.sv
// rtl/i2s_tdm_pkg.sv - shared types and field widths for the I2S/TDM clock and word-select generator
package i2s_tdm_pkg;

    localparam int WORD_W = 5;
    localparam int FCNT_W = 16;

    typedef enum logic [1:0] {
        MODE_I2S   = 2'd0,
        MODE_LJ    = 2'd1,
        MODE_DSP_A = 2'd2,
        MODE_DSP_B = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/i2s_tdm_clkws_gen_if.sv
// rtl/i2s_tdm_clkws_gen_if.sv - serial clock bundle from the divider to the position/word-select logic
interface i2s_tdm_clkws_gen_if;

    logic sck;
    logic sck_rise;
    logic sck_fall;
    // high in the cycle before sck_fall, i.e. on the edge where SCK is about to fall
    logic fall_tick;

    modport master (output sck, sck_rise, sck_fall, fall_tick);
    modport slave  (input  sck, sck_rise, sck_fall, fall_tick);

endinterface

// File: rtl/i2s_tdm_sck_div.sv
// rtl/i2s_tdm_sck_div.sv - SCK divider: half-period of div_i+1 clocks, level plus registered edge strobes
module i2s_tdm_sck_div #(
    parameter int DIV_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  run_i,
    input  logic [DIV_W-1:0]      div_i,
    i2s_tdm_clkws_gen_if.master   sck_if
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             tick;

    // Idle holds the counter and SCK at zero so every run starts with a full low half-period.
    always_comb begin
        tick   = run_i && (cnt_q == div_i);
        cnt_d  = '0;
        sck_d  = 1'b0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (run_i) begin
            cnt_d  = tick ? '0 : cnt_q + DIV_W'(1);
            sck_d  = tick ? ~sck_q : sck_q;
            rise_d = tick && !sck_q;
            fall_d = tick && sck_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q  <= '0;
            sck_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sck_q  <= sck_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign sck_if.sck       = sck_q;
    assign sck_if.sck_rise  = rise_q;
    assign sck_if.sck_fall  = fall_q;
    assign sck_if.fall_tick = fall_d;

endmodule

// File: rtl/i2s_tdm_clkws_gen.sv
// rtl/i2s_tdm_clkws_gen.sv - I2S/LJ/DSP frame timing generator; I2S_TDM_FRAME_CNT_EN enables frame_cnt_o
module i2s_tdm_clkws_gen
    import i2s_tdm_pkg::*;
#(
    parameter int DIV_W  = 16,
    parameter int SLOT_W = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_en_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    input  logic [WORD_W-1:0] cfg_word_size_i,
    input  logic [SLOT_W-1:0] cfg_slot_num_i,
    input  logic [1:0]        cfg_mode_i,
    output logic              sck_o,
    output logic              sck_rise_o,
    output logic              sck_fall_o,
    output logic              ws_o,
    output logic [SLOT_W-1:0] slot_idx_o,
    output logic [WORD_W-1:0] bit_idx_o,
    output logic              frame_start_o,
    output logic              busy_o,
    output logic [FCNT_W-1:0] frame_cnt_o
);

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SLOT_W-1:0]   snum_q, snum_d;
    mode_e               mode_q, mode_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [WORD_W-1:0]   bit_q, bit_d;
    logic                ws_q, ws_d;
    logic                fs_q, fs_d;
    logic                wrap;

    i2s_tdm_clkws_gen_if sck_if ();

    i2s_tdm_sck_div #(.DIV_W(DIV_W)) u_sck_div (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .run_i  (state_q != ST_IDLE),
        .div_i  (div_q),
        .sck_if (sck_if)
    );

    // Left-justified WS: second half of the slots, the odd middle slot going to the first half.
    function automatic logic lj_high(input logic [SLOT_W-1:0] slot, input logic [SLOT_W-1:0] snum);
        logic [SLOT_W:0] half;
        half = ({1'b0, snum} + (SLOT_W+1)'(2)) >> 1;
        return {1'b0, slot} >= half;
    endfunction

    function automatic logic ws_calc(input mode_e mode, input logic [SLOT_W-1:0] slot,
                                     input logic [WORD_W-1:0] bitn, input logic [WORD_W-1:0] word,
                                     input logic [SLOT_W-1:0] snum);
        logic            last_bit;
        logic [SLOT_W-1:0] nslot;
        last_bit = (bitn == word);
        nslot    = last_bit ? ((slot == snum) ? '0 : slot + SLOT_W'(1)) : slot;
        case (mode)
            MODE_I2S:   return lj_high(nslot, snum);
            MODE_LJ:    return lj_high(slot, snum);
            MODE_DSP_A: return (slot == snum) && last_bit;
            default:    return (slot == '0) && (bitn == '0);
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        word_d  = word_q;
        snum_d  = snum_q;
        mode_d  = mode_q;
        slot_d  = slot_q;
        bit_d   = bit_q;
        fs_d    = 1'b0;
        wrap    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_en_i) begin
                    state_d = ST_RUN;
                    div_d   = cfg_div_i;
                    word_d  = cfg_word_size_i;
                    snum_d  = cfg_slot_num_i;
                    mode_d  = mode_e'(cfg_mode_i);
                    slot_d  = '0;
                    bit_d   = '0;
                    fs_d    = 1'b1;
                end
            end
            default: begin
                state_d = cfg_en_i ? ST_RUN : ST_DRAIN;
                if (sck_if.fall_tick) begin
                    if (bit_q == word_q) begin
                        bit_d = '0;
                        if (slot_q == snum_q) begin
                            slot_d = '0;
                            wrap   = 1'b1;
                        end else begin
                            slot_d = slot_q + SLOT_W'(1);
                        end
                    end else begin
                        bit_d = bit_q + WORD_W'(1);
                    end
                end
                // A stop only takes effect on a frame boundary, so frames are never cut short.
                if (wrap) begin
                    if (cfg_en_i) fs_d    = 1'b1;
                    else          state_d = ST_IDLE;
                end
            end
        endcase
        ws_d = (state_d == ST_IDLE) ? 1'b0 : ws_calc(mode_d, slot_d, bit_d, word_d, snum_d);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            word_q  <= '0;
            snum_q  <= '0;
            mode_q  <= MODE_I2S;
            slot_q  <= '0;
            bit_q   <= '0;
            ws_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            word_q  <= word_d;
            snum_q  <= snum_d;
            mode_q  <= mode_d;
            slot_q  <= slot_d;
            bit_q   <= bit_d;
            ws_q    <= ws_d;
            fs_q    <= fs_d;
        end
    end

`ifdef I2S_TDM_FRAME_CNT_EN
    logic [FCNT_W-1:0] fcnt_q;

    // Counts completed frames: every boundary after the first frame_start, including the final one into idle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)   fcnt_q <= '0;
        else if (wrap) fcnt_q <= fcnt_q + FCNT_W'(1);
    end

    assign frame_cnt_o = fcnt_q;
`else
    assign frame_cnt_o = '0;
`endif

    assign sck_o         = sck_if.sck;
    assign sck_rise_o    = sck_if.sck_rise;
    assign sck_fall_o    = sck_if.sck_fall;
    assign ws_o          = ws_q;
    assign slot_idx_o    = slot_q;
    assign bit_idx_o     = bit_q;
    assign frame_start_o = fs_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
